// File: rtl/fft_psd_pkg.sv
// Shared types for the PSD averaging path: controller states and the
// complex sample layout produced by the FFT core (re in the upper half).
package fft_psd_pkg;

    localparam int CPLX_W = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } psd_state_t;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_t;

endpackage

// File: rtl/fft_cplx_mag_sq.sv
// One-cycle registered squared magnitude re^2 + im^2 with valid in/out.
// The result is unsigned and exactly PW bits wide; the worst case
// (-2^(DW-1))^2 * 2 = 2^(PW-1) still fits.
module fft_cplx_mag_sq #(
    parameter  int DW = 16,
    localparam int PW = 2 * DW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    output logic                 o_valid,
    output logic [PW-1:0]        o_pow
);

    logic signed [PW-1:0] w_re_ext;
    logic signed [PW-1:0] w_im_ext;
    logic signed [PW-1:0] w_re_sq;
    logic signed [PW-1:0] w_im_sq;

    // Sign-extend before multiplying so each square is exact in PW bits.
    assign w_re_ext = PW'(i_re);
    assign w_im_ext = PW'(i_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Valid flag follows the input; clear drops any beat in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
        end
    end

    // Power register; only meaningful while o_valid is high.
    // NOTE: datapath registers qualified by a valid need no reset.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            o_pow <= $unsigned(w_re_sq) + $unsigned(w_im_sq);
        end
    end

endmodule

// File: rtl/fft_psd_avg.sv
// Averages |X[k]|^2 over NUM_AVG consecutive FFT frames and streams the
// averaged spectrum out one bin per beat, with a last flag on the final bin.
// Pipeline: mag^2 register -> accumulator read-modify-write -> output register.
module fft_psd_avg
    import fft_psd_pkg::*;
#(
    parameter  int FFT_SIZE   = 16,
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_AVG    = 4,
    localparam int LOG2_FFT   = $clog2(FFT_SIZE),
    localparam int LOG2_AVG   = $clog2(NUM_AVG),
    localparam int POW_W      = 2 * DATA_WIDTH,
    localparam int ACC_W      = POW_W + LOG2_AVG
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    fft_in_valid_i,
    input  logic [2*DATA_WIDTH-1:0] fft_in_data_i,
    output logic                    fft_in_ready_o,
    output logic                    psd_valid_o,
    output logic [POW_W-1:0]        psd_data_o,
    output logic [LOG2_FFT-1:0]     psd_bin_o,
    output logic                    psd_last_o,
    input  logic                    psd_ready_i,
    output logic                    busy_o
);

    localparam int FRAME_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int RD_W    = LOG2_FFT + 1;

    localparam logic [LOG2_FFT-1:0] LAST_BIN   = LOG2_FFT'(FFT_SIZE - 1);
    localparam logic [FRAME_W-1:0]  LAST_FRAME = FRAME_W'(NUM_AVG - 1);
    localparam logic [RD_W-1:0]     RD_LAST    = RD_W'(FFT_SIZE - 1);
    localparam logic [RD_W-1:0]     RD_END     = RD_W'(FFT_SIZE);

    psd_state_t          r_state;
    psd_state_t          w_next_state;
    logic [LOG2_FFT-1:0] r_bin_cnt;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [RD_W-1:0]     r_rd_cnt;
    logic [LOG2_FFT-1:0] r_s1_bin;
    logic                r_s1_first;
    logic [ACC_W-1:0]    r_acc [FFT_SIZE];
    logic                r_psd_valid;
    logic [POW_W-1:0]    r_psd_data;
    logic [LOG2_FFT-1:0] r_psd_bin;
    logic                r_psd_last;

    logic                w_in_ready;
    logic                w_busy;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_pow_valid;
    logic [POW_W-1:0]    w_pow;
    logic                w_out_hs;
    logic                w_fetch;

    assign w_accept    = fft_in_valid_i && (r_state == ACCUM);
    assign w_last_beat = w_accept && (r_bin_cnt == LAST_BIN) && (r_frame_cnt == LAST_FRAME);
    assign w_out_hs    = r_psd_valid && psd_ready_i;
    // Load the output register when it is empty or being consumed this cycle.
    assign w_fetch     = (r_state == DRAIN) && (r_rd_cnt != RD_END) && (!r_psd_valid || psd_ready_i);

    // Stage 1: squared magnitude of the accepted beat.
    fft_cplx_mag_sq #(
        .DW (DATA_WIDTH)
    ) u_mag_sq (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_clear (clear_i),
        .i_valid (w_accept),
        .i_re    (fft_in_data_i[2*DATA_WIDTH-1:DATA_WIDTH]),
        .i_im    (fft_in_data_i[DATA_WIDTH-1:0]),
        .o_valid (w_pow_valid),
        .o_pow   (w_pow)
    );

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake/status decode.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        unique case (r_state)
            ACCUM: begin
                w_in_ready = 1'b1;
                if (w_last_beat) w_next_state = FLUSH;
            end
            FLUSH: begin
                w_busy = 1'b1;
                // The final beat has left stage 1 once its valid drops.
                if (!w_pow_valid) w_next_state = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (w_out_hs && r_psd_last) w_next_state = ACCUM;
            end
            default: w_next_state = ACCUM;
        endcase
    end

    // Bin and frame counters; both are back at zero when the last frame is taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_bin_cnt   <= '0;
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            r_bin_cnt <= r_bin_cnt + LOG2_FFT'(1);
            if (r_bin_cnt == LAST_BIN) begin
                r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Sideband for stage 2: which bin the power belongs to and whether to overwrite.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s1_bin   <= r_bin_cnt;
            r_s1_first <= (r_frame_cnt == '0);
        end
    end

    // Stage 2: overwrite on frame 0, accumulate on later frames.
    // NOTE: the accumulator array is not reset; frame 0 overwrites every bin before any read.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && w_pow_valid) begin
            if (r_s1_first) begin
                r_acc[r_s1_bin] <= ACC_W'(w_pow);
            end else begin
                r_acc[r_s1_bin] <= r_acc[r_s1_bin] + ACC_W'(w_pow);
            end
        end
    end

    // Drain read pointer: index of the next bin to load into the output register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i || (r_state != DRAIN)) begin
            r_rd_cnt <= '0;
        end else if (w_fetch) begin
            r_rd_cnt <= r_rd_cnt + RD_W'(1);
        end
    end

    // Output register: held while stalled, emptied after the last handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_psd_valid <= 1'b0;
            r_psd_data  <= '0;
            r_psd_bin   <= '0;
            r_psd_last  <= 1'b0;
        end else if (w_fetch) begin
            r_psd_valid <= 1'b1;
            r_psd_data  <= POW_W'(r_acc[r_rd_cnt[LOG2_FFT-1:0]] >> LOG2_AVG);
            r_psd_bin   <= r_rd_cnt[LOG2_FFT-1:0];
            r_psd_last  <= (r_rd_cnt == RD_LAST);
        end else if (w_out_hs) begin
            r_psd_valid <= 1'b0;
        end
    end

    assign fft_in_ready_o = w_in_ready;
    assign busy_o         = w_busy;
    assign psd_valid_o    = r_psd_valid;
    assign psd_data_o     = r_psd_data;
    assign psd_bin_o      = r_psd_bin;
    assign psd_last_o     = r_psd_last;

endmodule

// File: tb/tb_fft_psd_avg.sv
// Directed + randomized bench for fft_psd_avg. Expected spectra come from a
// plain arithmetic model: average over frames of re^2 + im^2 per bin.
module tb_fft_psd_avg;
    import fft_psd_pkg::*;

    localparam int FFT_SIZE = 16;
    localparam int DW       = 16;
    localparam int NUM_AVG  = 4;
    localparam int TOTAL    = FFT_SIZE * NUM_AVG;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          fft_in_valid_i;
    logic [2*DW-1:0] fft_in_data_i;
    logic          fft_in_ready_o;
    logic          psd_valid_o;
    logic [2*DW-1:0] psd_data_o;
    logic [3:0]    psd_bin_o;
    logic          psd_last_o;
    logic          psd_ready_i;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    logic signed [DW-1:0] s_re [TOTAL];
    logic signed [DW-1:0] s_im [TOTAL];

    fft_psd_avg #(
        .FFT_SIZE   (FFT_SIZE),
        .DATA_WIDTH (DW),
        .NUM_AVG    (NUM_AVG)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .fft_in_valid_i (fft_in_valid_i),
        .fft_in_data_i  (fft_in_data_i),
        .fft_in_ready_o (fft_in_ready_o),
        .psd_valid_o    (psd_valid_o),
        .psd_data_o     (psd_data_o),
        .psd_bin_o      (psd_bin_o),
        .psd_last_o     (psd_last_o),
        .psd_ready_i    (psd_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: mean over frames of the bin's squared magnitude.
    function automatic longint model_bin(int k);
        longint sum = 0;
        for (int f = 0; f < NUM_AVG; f++) begin
            longint re = s_re[f*FFT_SIZE + k];
            longint im = s_im[f*FFT_SIZE + k];
            sum += re * re + im * im;
        end
        return sum / NUM_AVG;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < TOTAL; i++) begin
            case (mode)
                0: begin s_re[i] = 16'(i % FFT_SIZE); s_im[i] = '0; end
                1: begin
                    s_re[i] = ((i % FFT_SIZE) == 3) ? 16'(100 * (i / FFT_SIZE + 1)) : '0;
                    s_im[i] = '0;
                end
                2: begin s_re[i] = 16'h8000; s_im[i] = 16'h8000; end
                3: begin s_re[i] = 16'($urandom()); s_im[i] = 16'($urandom()); end
                default: begin s_re[i] = 16'sd2; s_im[i] = 16'sd2; end
            endcase
        end
    endtask

    task automatic drive_in(input int idx, input bit rand_valid);
        complex_t c;
        if (idx < TOTAL) begin
            c.re = s_re[idx];
            c.im = s_im[idx];
            fft_in_valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            c.re = 16'($urandom());
            c.im = 16'($urandom());
            fft_in_valid_i = rand_valid;
        end
        fft_in_data_i = c;
    endtask

    // Feeds all frames from s_re/s_im and checks the complete drain.
    // Entered and left just after a rising edge.
    task automatic run_spectrum(input string name, input bit rand_valid, input bit toggle_ready);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        int last_in_cyc = -1;
        bit seen_out = 0;
        bit prev_stall = 0;
        bit drain_phase;
        logic [31:0] prev_data = '0;
        logic [3:0] prev_bin = '0;
        psd_ready_i = 1'b1;
        drive_in(in_idx, rand_valid);
        while (out_idx < FFT_SIZE && cyc < 3000) begin
            @(negedge clk_i);
            drain_phase = (in_idx == TOTAL);
            check({name, "/in_ready"}, fft_in_ready_o, !drain_phase);
            check({name, "/busy"}, busy_o, drain_phase);
            if (!drain_phase) check({name, "/no_early_out"}, psd_valid_o, 1'b0);
            if (psd_valid_o) begin
                if (!seen_out) begin
                    seen_out = 1;
                    check({name, "/latency"}, 64'(cyc - last_in_cyc), 64'd3);
                end
                check({name, "/bin"}, psd_bin_o, 64'(out_idx));
                check({name, "/data"}, psd_data_o, model_bin(out_idx));
                check({name, "/last"}, psd_last_o, out_idx == FFT_SIZE - 1);
                if (prev_stall) begin
                    check({name, "/hold_data"}, psd_data_o, prev_data);
                    check({name, "/hold_bin"}, psd_bin_o, prev_bin);
                end
            end
            prev_stall = psd_valid_o && !psd_ready_i;
            prev_data  = psd_data_o;
            prev_bin   = psd_bin_o;
            if (fft_in_valid_i && fft_in_ready_o && !drain_phase) begin
                in_idx++;
                if (in_idx == TOTAL) last_in_cyc = cyc + 1;
            end
            if (psd_valid_o && psd_ready_i) out_idx++;
            @(posedge clk_i);
            cyc++;
            #1;
            if (toggle_ready) psd_ready_i = ~psd_ready_i;
            drive_in(in_idx, rand_valid);
        end
        check({name, "/beats"}, 64'(out_idx), 64'(FFT_SIZE));
        fft_in_valid_i = 1'b0;
        psd_ready_i    = 1'b1;
        @(negedge clk_i);
        check({name, "/post_valid"}, psd_valid_o, 1'b0);
        check({name, "/post_ready"}, fft_in_ready_o, 1'b1);
        check({name, "/post_busy"}, busy_o, 1'b0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic feed_const(input int n, input logic signed [DW-1:0] re);
        complex_t c;
        c.re = re;
        c.im = '0;
        fft_in_data_i  = c;
        fft_in_valid_i = 1'b1;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
        fft_in_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        complex_t c;
        rst_ni         = 1'b0;
        clear_i        = 1'b0;
        fft_in_valid_i = 1'b0;
        fft_in_data_i  = '0;
        psd_ready_i    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst/valid", psd_valid_o, 1'b0);
        check("rst/data", psd_data_o, 64'd0);
        check("rst/bin", psd_bin_o, 64'd0);
        check("rst/last", psd_last_o, 1'b0);
        check("rst/busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst/in_ready", fft_in_ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        // 1: ramp re=k, continuous valid
        fill(0);
        run_spectrum("ramp", 0, 0);

        // 2: single active bin averaged over frames
        fill(1);
        run_spectrum("bin3", 0, 0);

        // 3: most negative inputs, maximum power
        fill(2);
        run_spectrum("maxneg", 0, 0);

        // 4: random data, random valid, stalling downstream
        fill(3);
        run_spectrum("rand_stall", 1, 1);

        // 5: partial accumulation discarded by clear
        feed_const(2 * FFT_SIZE + 5, 16'sd1000);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        fill(4);
        run_spectrum("clear_mid", 0, 0);

        // 6: clear while bin 7 is pending in the drain
        fill(3);
        fft_in_valid_i = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            c.re = s_re[i];
            c.im = s_im[i];
            fft_in_data_i = c;
            @(posedge clk_i);
            #1;
        end
        fft_in_valid_i = 1'b0;
        n = 0;
        while (!(psd_valid_o && psd_bin_o == 4'd7) && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        psd_ready_i = 1'b0;
        check("abort/bin7", psd_bin_o, 64'd7);
        check("abort/data7", psd_data_o, model_bin(7));
        @(posedge clk_i);
        #1;
        check("abort/held", psd_bin_o, 64'd7);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        psd_ready_i = 1'b1;
        check("abort/valid", psd_valid_o, 1'b0);
        check("abort/in_ready", fft_in_ready_o, 1'b1);
        check("abort/busy", busy_o, 1'b0);

        // Fresh spectrum after the abort
        fill(3);
        run_spectrum("after_abort", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_psd_avg.md
Name: fft_psd_avg

Overview:
Downstream consumer of the FFT core's complex output stream. Computes per-bin power |X[k]|^2 = re^2 + im^2 and accumulates it over NUM_AVG consecutive FFT frames. It then streams out the averaged power spectrum, one bin per beat, with a last flag. It sits between the FFT core output port and the spectrum readout or bus interface.

Parameters:
FFT_SIZE, 16, bins per frame; power of 2, >= 4.
DATA_WIDTH, 16, width of each of re/im in the input sample.
NUM_AVG, 4, frames averaged per output spectrum; power of 2, >= 1.
(derived) LOG2_FFT = $clog2(FFT_SIZE); LOG2_AVG = $clog2(NUM_AVG); POW_W = 2*DATA_WIDTH; ACC_W = POW_W + LOG2_AVG.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  synchronous abort; restarts averaging from frame 0
fft_in_valid_i  in  1  input beat valid
fft_in_data_i  in  2*DATA_WIDTH  signed complex; re = [2*DW-1:DW], im = [DW-1:0]
fft_in_ready_o  out  1  input beat accepted when valid&ready
psd_valid_o  out  1  output beat valid
psd_data_o  out  POW_W  averaged power, unsigned
psd_bin_o  out  LOG2_FFT  bin index of psd_data_o
psd_last_o  out  1  high on bin FFT_SIZE-1
psd_ready_i  in  1  downstream ready
busy_o  out  1  high in FLUSH or DRAIN

Behaviour:
- Reset: one clock, synchronous, active-low. Registers update on the clk_i edge where rst_ni=0: state=ACCUM, bin_cnt=0, frame_cnt=0, pipeline valids=0. Output values: psd_valid_o=0, psd_data_o=0, psd_bin_o=0, psd_last_o=0, busy_o=0. fft_in_ready_o=1 from the first cycle after reset.
- Input beats arrive in natural bin order 0..FFT_SIZE-1. The first accepted beat after reset, clear or drain is bin 0 of frame 0.
- Stage 1 (registered): re*re and im*im as signed DW x DW products, then summed into unsigned POW_W. The maximum 2^31 (both inputs -2^(DW-1)) fits without overflow.
- Stage 2 (registered): read-modify-write of accumulator array acc[FFT_SIZE] (ACC_W bits each).
  - frame_cnt==0: acc[bin] <= pow (overwrite).
  - otherwise: acc[bin] <= acc[bin] + pow.
  - Bins are strictly sequential, so there is no read-after-write hazard.
- Counters: bin_cnt increments per accepted beat and wraps FFT_SIZE-1 -> 0. On that wrap, frame_cnt increments.
- FSM states: ACCUM, FLUSH, DRAIN.
  - ACCUM: fft_in_ready_o=1. Acceptance of bin FFT_SIZE-1 with frame_cnt==NUM_AVG-1 moves to FLUSH. Input gaps (valid=0) are allowed and stall nothing.
  - FLUSH: fft_in_ready_o=0. Lasts exactly 2 cycles, until the pipeline is empty, then moves to DRAIN with rd_cnt=0.
  - DRAIN: fft_in_ready_o=0, psd_valid_o=1.
    - psd_data_o = acc[rd_cnt] >> LOG2_AVG (truncating). psd_bin_o = rd_cnt. psd_last_o = (rd_cnt==FFT_SIZE-1).
    - Outputs are registered and held stable while psd_ready_i=0.
    - Each handshake increments rd_cnt.
    - The handshake with last=1 returns to ACCUM with frame_cnt=0, bin_cnt=0, and psd_valid_o=0 on the next cycle.
- Latency: the first psd_valid_o rises 3 cycles after the final input handshake. Drain takes FFT_SIZE beats at 1 beat/cycle when psd_ready_i=1.
- clear_i: same effect as reset, regardless of state (mid-frame, FLUSH, or mid-DRAIN with a pending beat). Stale accumulator contents are harmless because frame 0 overwrites every bin.
- clear_i and rst_ni both active: reset wins (same result).
- NUM_AVG=1: LOG2_AVG=0, so there is no shift; every frame is drained.

Decomposition:
- Package fft_psd_pkg: enum psd_state_t {ACCUM, FLUSH, DRAIN}; complex_t struct (re, im signed DATA_WIDTH) shared with the FFT core's output format.
- Sub-module fft_cplx_mag_sq: a 1-cycle registered |x|^2 block with valid in/out. It is reusable for the magnitude readout.

Test Plan:
(FFT_SIZE=16, DATA_WIDTH=16, NUM_AVG=4 throughout.)
1. All 4 frames: bin k re=k, im=0, valid continuous, psd_ready_i=1 -> 16 beats, psd_data_o=k^2 on bin k, last only on bin 15; first valid 3 cycles after the 64th input handshake.
2. Bin 3 re=100/200/300/400 over frames 0..3, im=0; others 0 -> bin 3 = 300000/4 = 75000, other bins 0.
3. Every beat re=-32768, im=-32768 -> every bin = 0x80000000; no wrap.
4. psd_ready_i toggling 1010...; random input valid; input presented during drain -> psd outputs stable while stalled, fft_in_ready_o=0 through FLUSH and DRAIN, exactly 16 output beats.
5. After 2 frames + 5 bins of re=1000, pulse clear_i, then 4 frames re=2, im=2 -> every bin = 8; no trace of the earlier data.
6. clear_i during DRAIN at bin 7 with psd_ready_i=0 -> next cycle psd_valid_o=0, fft_in_ready_o=1, busy_o=0.
